// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Multiplexed seven-segment scanner with a double-buffered
//               frame image, per-digit blink/blank masks and a frame pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
    parameter int DIGITS  = 4,
    parameter int DIV_W   = 16,
    parameter int BLINK_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [5*DIGITS-1:0]   codes,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [DIGITS-1:0]     seg_selector,
    output logic [7:0]            segments,
    output logic                  frame_done
);

    localparam int                 c_idx_w      = $clog2(DIGITS);
    localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(DIGITS - 1);
    localparam logic [4:0]         c_blank_code = 5'h0F;

    logic [DIV_W-1:0]    r_presc,      w_presc_nxt;
    logic [c_idx_w-1:0]  r_index,      w_index_nxt;
    logic [BLINK_W-1:0]  r_blink,      w_blink_nxt;
    logic [5*DIGITS-1:0] r_pend_codes, w_pend_codes_nxt;
    logic [DIGITS-1:0]   r_pend_blink, w_pend_blink_nxt;
    logic [DIGITS-1:0]   r_pend_blank, w_pend_blank_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
    logic [5*DIGITS-1:0] r_act_codes,  w_act_codes_nxt;
    logic [DIGITS-1:0]   r_act_blink,  w_act_blink_nxt;
    logic [DIGITS-1:0]   r_act_blank,  w_act_blank_nxt;
    logic [DIGITS-1:0]   r_sel,        w_sel_nxt;
    logic [7:0]          r_seg,        w_seg_nxt;
    logic                r_frame_done, w_frame_done_nxt;

    logic                w_tick;
    logic                w_wrap;
    logic [4:0]          w_cur_code;
    logic                w_cur_blink;
    logic                w_cur_blank;
    logic [DIGITS-1:0]   w_cur_sel;
    logic                w_dark;

    function automatic logic [7:0] f_glyph(input logic [3:0] g);
        case (g)
            4'd0:    f_glyph = 8'h03;
            4'd1:    f_glyph = 8'h9F;
            4'd2:    f_glyph = 8'h25;
            4'd3:    f_glyph = 8'h0D;
            4'd4:    f_glyph = 8'h99;
            4'd5:    f_glyph = 8'h49;
            4'd6:    f_glyph = 8'h41;
            4'd7:    f_glyph = 8'h1F;
            4'd8:    f_glyph = 8'h01;
            4'd9:    f_glyph = 8'h09;
            4'd10:   f_glyph = 8'h11;
            4'd11:   f_glyph = 8'hC1;
            4'd12:   f_glyph = 8'h63;
            4'd13:   f_glyph = 8'h31;
            4'd14:   f_glyph = 8'hFD;
            default: f_glyph = 8'hFF;
        endcase
    endfunction

    always_comb begin
        w_tick      = en && (r_presc == '1);
        w_wrap      = w_tick && (r_index == c_last_idx);
        w_presc_nxt = en ? r_presc + DIV_W'(1) : r_presc;
        w_blink_nxt = en ? r_blink + BLINK_W'(1) : r_blink;
        w_index_nxt = r_index;
        if (w_tick) begin
            w_index_nxt = w_wrap ? '0 : r_index + c_idx_w'(1);
        end

        w_pend_codes_nxt = r_pend_codes;
        w_pend_blink_nxt = r_pend_blink;
        w_pend_blank_nxt = r_pend_blank;
        w_pend_valid_nxt = r_pend_valid;
        w_act_codes_nxt  = r_act_codes;
        w_act_blink_nxt  = r_act_blink;
        w_act_blank_nxt  = r_act_blank;
        // Promotion reads the registered pending image, so a load landing on
        // the wrap tick survives as the next frame's pending value.
        if (w_wrap && r_pend_valid) begin
            w_act_codes_nxt  = r_pend_codes;
            w_act_blink_nxt  = r_pend_blink;
            w_act_blank_nxt  = r_pend_blank;
            w_pend_valid_nxt = 1'b0;
        end
        if (load) begin
            w_pend_codes_nxt = codes;
            w_pend_blink_nxt = blink_mask;
            w_pend_blank_nxt = blank_mask;
            w_pend_valid_nxt = 1'b1;
        end
        w_frame_done_nxt = w_wrap;
    end

    always_comb begin
        w_cur_code  = c_blank_code;
        w_cur_blink = 1'b0;
        w_cur_blank = 1'b0;
        w_cur_sel   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_index == c_idx_w'(i)) begin
                w_cur_code   = r_act_codes[5*i +: 5];
                w_cur_blink  = r_act_blink[i];
                w_cur_blank  = r_act_blank[i];
                w_cur_sel[i] = 1'b0;
            end
        end
        w_dark = w_cur_blank || (w_cur_blink && r_blink[BLINK_W-1]) ||
                 (w_cur_code[3:0] == 4'hF);

        w_sel_nxt = '1;
        w_seg_nxt = 8'hFF;
        if (en) begin
            w_sel_nxt = w_cur_sel;
            if (!w_dark) begin
                w_seg_nxt = f_glyph(w_cur_code[3:0]) & {7'h7F, ~w_cur_code[4]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_index      <= '0;
            r_blink      <= '0;
            r_pend_codes <= {DIGITS{c_blank_code}};
            r_pend_blink <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
            r_act_codes  <= {DIGITS{c_blank_code}};
            r_act_blink  <= '0;
            r_act_blank  <= '0;
            r_sel        <= '1;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_index      <= w_index_nxt;
            r_blink      <= w_blink_nxt;
            r_pend_codes <= w_pend_codes_nxt;
            r_pend_blink <= w_pend_blink_nxt;
            r_pend_blank <= w_pend_blank_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_act_codes  <= w_act_codes_nxt;
            r_act_blink  <= w_act_blink_nxt;
            r_act_blank  <= w_act_blank_nxt;
            r_sel        <= w_sel_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign seg_selector = r_sel;
    assign segments     = r_seg;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_display
// Description : Directed self-checking bench for seg_scan_display
//               (DIGITS=4, DIV_W=2, BLINK_W=4: 4 clocks/digit, 16 clocks/frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_display;

    localparam int DIGITS  = 4;
    localparam int DIV_W   = 2;
    localparam int BLINK_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                load;
    logic [5*DIGITS-1:0] codes;
    logic [DIGITS-1:0]   blink_mask;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   seg_selector;
    logic [7:0]          segments;
    logic                frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .DIGITS  (DIGITS),
        .DIV_W   (DIV_W),
        .BLINK_W (BLINK_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .load         (load),
        .codes        (codes),
        .blink_mask   (blink_mask),
        .blank_mask   (blank_mask),
        .seg_selector (seg_selector),
        .segments     (segments),
        .frame_done   (frame_done)
    );

    function automatic logic [19:0] pack(input logic [4:0] d3, d2, d1, d0);
        pack = {d3, d2, d1, d0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sel, input logic [7:0] seg);
        chk({tag, " sel"}, {4'h0, seg_selector}, {4'h0, sel});
        chk({tag, " seg"}, segments, seg);
    endtask

    task automatic load_at(input logic [19:0] c, input logic [3:0] bk, input logic [3:0] bl);
        load       = 1'b1;
        codes      = c;
        blink_mask = bk;
        blank_mask = bl;
        tick(1);
        load       = 1'b0;
    endtask

    // Called on the first clock that shows digit 0; checks one full frame.
    task automatic check_frame(input string tag, input logic [7:0] e0, e1, e2, e3);
        logic [7:0] exp_seg [4];
        exp_seg = '{e0, e1, e2, e3};
        for (int k = 0; k < 16; k++) begin
            logic [3:0] exp_sel;
            exp_sel = ~(4'b0001 << (k / 4));
            chk($sformatf("%s sel k=%0d", tag, k), {4'h0, seg_selector}, {4'h0, exp_sel});
            chk($sformatf("%s seg k=%0d", tag, k), segments, exp_seg[k / 4]);
            chk($sformatf("%s fd k=%0d", tag, k), {7'h0, frame_done}, (k == 15) ? 8'h01 : 8'h00);
            tick(1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        load       = 1'b0;
        codes      = '0;
        blink_mask = '0;
        blank_mask = '0;
        tick(2);
        chk_out("reset", 4'b1111, 8'hFF);
        chk("reset fd", {7'h0, frame_done}, 8'h00);

        // Scan: load lands in pending, goes active at the first wrap.
        rst = 1'b0;
        en  = 1'b1;
        load_at(pack(5'h03, 5'h02, 5'h01, 5'h00), 4'b0000, 4'b0000);
        chk_out("scan start", 4'b1110, 8'hFF);
        tick(15);
        chk_out("scan pre-wrap", 4'b0111, 8'hFF);
        chk("scan wrap fd", {7'h0, frame_done}, 8'h01);
        tick(1);
        check_frame("scan", 8'h03, 8'h9F, 8'h25, 8'h0D);

        // Mid-frame load: old glyphs stay until the wrap.
        load_at(pack(5'h0E, 5'h0A, 5'h0B, 5'h0C), 4'b0000, 4'b0000);
        chk_out("fb old d0", 4'b1110, 8'h03);
        tick(6);
        chk_out("fb old d1", 4'b1101, 8'h9F);
        tick(8);
        chk_out("fb old d3", 4'b0111, 8'h0D);
        chk("fb wrap fd", {7'h0, frame_done}, 8'h01);
        tick(1);
        check_frame("fb new", 8'h63, 8'hC1, 8'h11, 8'hFD);

        // Load A mid-frame, then load B on the wrapping tick.
        load_at(pack(5'h07, 5'h06, 5'h05, 5'h04), 4'b0000, 4'b0000);
        tick(13);
        load_at(pack(5'h1F, 5'h10, 5'h09, 5'h08), 4'b0000, 4'b0000);
        chk("sim wrap fd", {7'h0, frame_done}, 8'h01);
        chk_out("sim pre-wrap", 4'b0111, 8'hFD);
        tick(1);
        check_frame("sim A", 8'h99, 8'h49, 8'h41, 8'h1F);
        check_frame("sim B", 8'h01, 8'h09, 8'h02, 8'hFF);

        // Masks. Blink period equals the frame period here, so digit 1 always
        // sees phase 0 (glyph) and digit 2 always sees phase 1 (dark).
        load_at(pack(5'h03, 5'h02, 5'h01, 5'h00), 4'b0110, 4'b0001);
        tick(15);
        check_frame("mask", 8'hFF, 8'h9F, 8'hFF, 8'h0D);

        // Enable pause at index 2 with two prescaler counts left.
        load_at(pack(5'h03, 5'h02, 5'h01, 5'h00), 4'b0000, 4'b0000);
        tick(15);
        tick(9);
        chk_out("pause before", 4'b1011, 8'h25);
        en = 1'b0;
        tick(1);
        chk_out("pause off", 4'b1111, 8'hFF);
        load_at(pack(5'h0B, 5'h0C, 5'h0D, 5'h0E), 4'b0000, 4'b0000);
        tick(4);
        chk_out("pause hold", 4'b1111, 8'hFF);
        chk("pause fd", {7'h0, frame_done}, 8'h00);
        en = 1'b1;
        tick(1);
        chk_out("resume d2a", 4'b1011, 8'h25);
        tick(1);
        chk_out("resume d2b", 4'b1011, 8'h25);
        tick(1);
        chk_out("resume d3", 4'b0111, 8'h0D);
        tick(3);
        chk("resume wrap fd", {7'h0, frame_done}, 8'h01);
        tick(1);
        check_frame("pause load", 8'hFD, 8'h31, 8'h63, 8'hC1);

        // Reset mid-frame with a load pending and a load coincident with rst.
        load_at(pack(5'h00, 5'h00, 5'h00, 5'h00), 4'b0000, 4'b0000);
        tick(3);
        rst   = 1'b1;
        load  = 1'b1;
        codes = pack(5'h08, 5'h08, 5'h08, 5'h08);
        tick(1);
        chk_out("midrst", 4'b1111, 8'hFF);
        chk("midrst fd", {7'h0, frame_done}, 8'h00);
        rst  = 1'b0;
        load = 1'b0;
        tick(1);
        chk_out("midrst restart", 4'b1110, 8'hFF);
        tick(15);
        chk("midrst wrap fd", {7'h0, frame_done}, 8'h01);
        tick(1);
        check_frame("midrst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The block SHALL have the following parameters:
- DIGITS, default 4, number of multiplexed digits (legal range 2..8).
- DIV_W, default 16, prescaler width; the scan advances every 2^DIV_W clocks.
- BLINK_W, default 24, width of the blink counter; its MSB is the blink phase.

REQ-002 The block SHALL have the following ports (clock and reset first):
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- en  in  1  scan enable.
- load  in  1  one-cycle strobe; captures codes/blink_mask/blank_mask into the pending buffer.
- codes  in  5*DIGITS  per-digit code; digit i uses bits [5i+4:5i]. Code bits [3:0] = glyph, bit [4] = decimal point on.
- blink_mask  in  DIGITS  1 = digit blinks.
- blank_mask  in  DIGITS  1 = digit forced dark.
- seg_selector  out  DIGITS  active-low digit enables; bit i drives digit i.
- segments  out  8  active-low segments, bit order a,b,c,d,e,f,g,dp (bit7..bit0).
- frame_done  out  1  one-cycle pulse at frame wrap.

Function
REQ-003 The prescaler SHALL count 0..2^DIV_W-1 while en=1, hold its value while en=0, and assert an internal tick when it equals 2^DIV_W-1.
REQ-004 On each tick, the digit index SHALL advance by 1, wrapping from DIGITS-1 to 0; the index width SHALL be clog2(DIGITS), with unused index values never reached.
REQ-005 The block SHALL keep two buffers, pending and active, each holding codes, blink_mask and blank_mask.
REQ-006 load=1 SHALL overwrite the pending buffer and set a pending-valid flag; repeated loads within one frame SHALL leave only the last value (last wins).
REQ-007 On the tick that wraps the index DIGITS-1 -> 0:
- If pending-valid=1, the active buffer SHALL be copied from pending and pending-valid cleared.
- The copy SHALL use the pending contents held before any same-cycle load.
- A same-cycle load SHALL remain pending for the next frame, with pending-valid left set.
REQ-008 frame_done SHALL pulse high for exactly one clock, in the cycle after the wrapping tick.
REQ-009 The blink counter SHALL increment every clock while en=1 and hold while en=0; blink phase = counter MSB.
REQ-010 seg_selector and segments SHALL be registered, reflecting the index and active buffer with one clock of latency.
REQ-011 While en=1, seg_selector SHALL drive bit [index] low and all other bits high.
REQ-012 The current digit SHALL display dark (segments=8'hFF) when any of the following holds:
- its blank_mask bit=1;
- its blink_mask bit=1 and blink phase=1;
- its glyph=15.
Otherwise segments SHALL be the glyph pattern below, with bit0 cleared when code bit4=1.
REQ-013 The glyph table SHALL be:
- Digits 0..9: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09.
- Letters and symbols: 10 A=11, 11 b=C1, 12 C=63, 13 P=31, 14 '-'=FD.
- 15 = blank (FF).
REQ-014 When en=0, the block SHALL drive seg_selector all-ones and segments=8'hFF from the next clock. The index and buffers SHALL hold, and load SHALL still be accepted into the pending buffer.
REQ-015 When en returns to 1, scanning SHALL resume from the held index and prescaler value, with no skipped or repeated digit.
REQ-016 The block SHALL use no combinational path from inputs to outputs.

Reset
REQ-017 While rst=1, on the clock edge the block SHALL:
- clear the prescaler, blink counter, index and pending-valid;
- load the active and pending codes with 5'h0F (blank, dp off) and clear both masks;
- drive seg_selector all-ones, segments=8'hFF and frame_done=0.
REQ-018 rst SHALL take priority over en and load.
REQ-019 A reset mid-frame SHALL discard any pending load and restart the scan at digit 0 on the first tick after rst deasserts.

Verification
REQ-020 With DIGITS=4, DIV_W=2 and BLINK_W=4, the bench SHALL cover the following directed scenarios:
- Scan: rst, then en=1, load codes {3,2,1,0} once → after the first frame wrap, seg_selector cycles 1110,1101,1011,0111 holding 4 clocks each, with segments 03,9F,25,0D respectively.
- Frame-boundary load: load codes {0x0C,...} mid-frame → digits keep the old glyphs until the wrap; the new glyphs appear from the wrap; frame_done pulses once per 16 clocks.
- Simultaneous load and wrap: load on the wrapping tick → the prior pending value goes active and the new value goes active one frame (16 clocks) later.
- Masks: blank_mask=0001 → digit 0 shows FF permanently. blink_mask=0010 → digit 1 shows FF whenever the blink counter MSB=1 (8 clocks on, 8 off) and its glyph otherwise. Code 5'h10 → segments 02.
- Enable and reset: en=0 mid-frame at index 2 → outputs FF/1111 next clock; en=1 → resumes at index 2 with the remaining prescaler count. rst mid-frame with load pending → all outputs blank, and the pending value is never displayed.
